slave_arb: RTL and testbench
============================

SLAVE_ARB -- requirements
Module: slave_arb

Interface
REQ-001 SHALL have parameter CMD_W, default 1, command width per master.
REQ-002 SHALL have parameter AW, default 12, address width.
REQ-003 SHALL have parameter DW, default 32, data width.
REQ-004 SHALL have parameter SW, default 4, byte-select width.
REQ-005 SHALL have parameter TO_CYC, default 16, timeout in cycles of oSlvReq high (used only with SLAVE_ARB_TIMEOUT_EN).
REQ-006 SHALL have port iClk, input, 1, clock; all state on its rising edge.
REQ-007 SHALL have port iRst_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port iMstReq, input, 4, per-master request from each master-side decoder; bit N = master N.
REQ-009 SHALL have port iMstCmd, input, 4*CMD_W, packed commands; slice N = master N.
REQ-010 SHALL have port iMstAddr, input, 4*AW, packed addresses.
REQ-011 SHALL have port iMstSel, input, 4*SW, packed byte selects.
REQ-012 SHALL have port iMstWData, input, 4*DW, packed write data.
REQ-013 SHALL have port oMstAck, output, 4, one-cycle ack pulse to the granted master.
REQ-014 SHALL have port oMstErr, output, 4, error flag, valid with oMstAck.
REQ-015 SHALL have port oMstRData, output, DW, shared read data, valid while any oMstAck bit is high.
REQ-016 SHALL have ports oSlvReq (1), oSlvCmd (CMD_W), oSlvAddr (AW), oSlvSel (SW), oSlvWData (DW), outputs, request and fields to the slave.
REQ-017 SHALL have ports iSlvAck (1), iSlvRData (DW), inputs, slave response.

Function
REQ-018 SHALL implement states IDLE, BUSY, ACK, RELEASE, encoded in registers.
REQ-019 In IDLE with iMstReq nonzero, SHALL grant index g = first set bit searching ptr, ptr+1, ... mod 4, latch g and master g's cmd/addr/sel/wdata into registers, set ptr <= (g+1) mod 4, and go to BUSY.
REQ-020 In BUSY, oSlvReq SHALL be 1 and oSlv* fields SHALL be the latched values, stable until exit; oSlvReq is registered (first high the cycle after the grant edge).
REQ-021 In BUSY with iSlvAck=1, SHALL capture iSlvRData and go to ACK; oSlvReq SHALL be 0 from the next cycle.
REQ-022 In ACK (exactly one cycle), oMstAck[g]=1, oMstRData = captured data, all other oMstAck bits 0; next state RELEASE.
REQ-023 In RELEASE, SHALL stay until iMstReq[g]=0, then go to IDLE; requests from other masters SHALL NOT be granted before IDLE.
REQ-024 Deassertion of iMstReq[g] during BUSY SHALL NOT abort the transaction; it completes normally.
REQ-025 Minimum latency: grant edge to oSlvReq = 1 cycle; iSlvAck to oMstAck = 1 cycle.
REQ-026 oMstRData SHALL be 0 and oMstAck 0 outside ACK; oSlv* fields SHALL hold last latched values when oSlvReq=0.
REQ-027 iSlvAck outside BUSY SHALL be ignored.

Reset
REQ-028 On iRst_n=0, SHALL asynchronously force state IDLE, ptr 0, oSlvReq 0, oMstAck 0, oMstErr 0, oMstRData 0, latched fields 0, timeout counter 0, including mid-transaction; no ack is issued for an aborted transaction.

Configuration
REQ-029 With SLAVE_ARB_TIMEOUT_EN defined, SHALL count BUSY cycles; when count reaches TO_CYC without iSlvAck, SHALL leave BUSY to ACK with oMstErr[g]=1, oMstRData all-ones, oSlvReq 0 next cycle; counter clears on BUSY entry.
REQ-030 With SLAVE_ARB_TIMEOUT_EN defined, iSlvAck on the expiry cycle SHALL win: normal ack, oMstErr 0.
REQ-031 Without SLAVE_ARB_TIMEOUT_EN, no counter SHALL exist, BUSY waits indefinitely, oMstErr tied 0.

Verification
REQ-032 Reset, iMstReq=4'b0001, addr 0x004, slave acks 3 cycles after oSlvReq with 0xA5A5A5A5 -> oSlvAddr=0x004, oMstAck=4'b0001 one cycle, oMstRData=0xA5A5A5A5.
REQ-033 iMstReq=4'b1111 held, each master drops req one cycle after its ack then reasserts -> grant order 0,1,2,3,0.
REQ-034 Grant master 2, then iMstReq[2] held high after ack for 5 cycles while iMstReq[1]=1 -> master 1 not granted until iMstReq[2]=0.
REQ-035 iRst_n pulsed low in BUSY -> oSlvReq=0 immediately, no oMstAck, next grant starts at master 0.
REQ-036 With SLAVE_ARB_TIMEOUT_EN, TO_CYC=16, slave never acks -> oMstAck[g]=1, oMstErr[g]=1, oMstRData=0xFFFFFFFF after 16 BUSY cycles; ack on cycle 16 -> oMstErr=0.

Source files
------------

// File: rtl/slave_arb.sv
// Four-master round-robin arbiter in front of a single slave port.
// Optional BUSY timeout with error response when SLAVE_ARB_TIMEOUT_EN is defined.
module slave_arb #(
  parameter int unsigned CMD_W  = 1,
  parameter int unsigned AW     = 12,
  parameter int unsigned DW     = 32,
  parameter int unsigned SW     = 4,
  parameter int unsigned TO_CYC = 16
) (
  input  logic              iClk,
  input  logic              iRst_n,
  input  logic [3:0]        iMstReq,
  input  logic [4*CMD_W-1:0] iMstCmd,
  input  logic [4*AW-1:0]   iMstAddr,
  input  logic [4*SW-1:0]   iMstSel,
  input  logic [4*DW-1:0]   iMstWData,
  output logic [3:0]        oMstAck,
  output logic [3:0]        oMstErr,
  output logic [DW-1:0]     oMstRData,
  output logic              oSlvReq,
  output logic [CMD_W-1:0]  oSlvCmd,
  output logic [AW-1:0]     oSlvAddr,
  output logic [SW-1:0]     oSlvSel,
  output logic [DW-1:0]     oSlvWData,
  input  logic              iSlvAck,
  input  logic [DW-1:0]     iSlvRData
);

  typedef enum logic [1:0] {StIdle, StBusy, StAck, StRelease} state_e;

  state_e           state_q;
  logic [1:0]       ptr_q;
  logic [1:0]       gnt_q;
  logic [CMD_W-1:0] cmd_q;
  logic [AW-1:0]    addr_q;
  logic [SW-1:0]    sel_q;
  logic [DW-1:0]    wdata_q;
  logic             slv_req_q;
  logic [3:0]       mst_ack_q;
  logic [DW-1:0]    mst_rdata_q;

  logic [1:0]       gnt_idx;
  logic [1:0]       cand;
  logic             gnt_vld;

  // Rotating priority: search starts at ptr_q and wraps.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = ptr_q;
    cand    = ptr_q;
    for (int i = 0; i < 4; i++) begin
      cand = ptr_q + 2'(i);
      if (!gnt_vld && iMstReq[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end

`ifdef SLAVE_ARB_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TO_CYC + 1);

  logic [TO_W-1:0] to_cnt_q;
  logic [3:0]      mst_err_q;
  logic            to_expired;

  // Counter holds the number of BUSY cycles already completed.
  assign to_expired = (to_cnt_q == TO_W'(TO_CYC - 1));
  assign oMstErr    = mst_err_q;
`else
  assign oMstErr    = '0;
`endif

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      gnt_q       <= '0;
      cmd_q       <= '0;
      addr_q      <= '0;
      sel_q       <= '0;
      wdata_q     <= '0;
      slv_req_q   <= 1'b0;
      mst_ack_q   <= '0;
      mst_rdata_q <= '0;
`ifdef SLAVE_ARB_TIMEOUT_EN
      to_cnt_q    <= '0;
      mst_err_q   <= '0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (gnt_vld) begin
            state_q   <= StBusy;
            gnt_q     <= gnt_idx;
            ptr_q     <= gnt_idx + 2'd1;
            cmd_q     <= iMstCmd[gnt_idx*CMD_W +: CMD_W];
            addr_q    <= iMstAddr[gnt_idx*AW +: AW];
            sel_q     <= iMstSel[gnt_idx*SW +: SW];
            wdata_q   <= iMstWData[gnt_idx*DW +: DW];
            slv_req_q <= 1'b1;
`ifdef SLAVE_ARB_TIMEOUT_EN
            to_cnt_q  <= '0;
`endif
          end
        end
        StBusy: begin
          // A slave ack on the expiry cycle takes precedence over the timeout.
          if (iSlvAck) begin
            state_q     <= StAck;
            slv_req_q   <= 1'b0;
            mst_ack_q   <= 4'b0001 << gnt_q;
            mst_rdata_q <= iSlvRData;
          end
`ifdef SLAVE_ARB_TIMEOUT_EN
          else if (to_expired) begin
            state_q     <= StAck;
            slv_req_q   <= 1'b0;
            mst_ack_q   <= 4'b0001 << gnt_q;
            mst_err_q   <= 4'b0001 << gnt_q;
            mst_rdata_q <= '1;
          end else begin
            to_cnt_q    <= to_cnt_q + TO_W'(1);
          end
`endif
        end
        StAck: begin
          state_q     <= StRelease;
          mst_ack_q   <= '0;
          mst_rdata_q <= '0;
`ifdef SLAVE_ARB_TIMEOUT_EN
          mst_err_q   <= '0;
`endif
        end
        StRelease: begin
          if (!iMstReq[gnt_q]) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign oMstAck   = mst_ack_q;
  assign oMstRData = mst_rdata_q;
  assign oSlvReq   = slv_req_q;
  assign oSlvCmd   = cmd_q;
  assign oSlvAddr  = addr_q;
  assign oSlvSel   = sel_q;
  assign oSlvWData = wdata_q;

endmodule

// File: tb/tb_slave_arb.sv
// Directed self-checking bench for slave_arb (default parameters).
// Timeout vectors are compiled in when SLAVE_ARB_TIMEOUT_EN is defined.
module tb_slave_arb;

  logic         iClk;
  logic         iRst_n;
  logic [3:0]   iMstReq;
  logic [3:0]   iMstCmd;
  logic [47:0]  iMstAddr;
  logic [15:0]  iMstSel;
  logic [127:0] iMstWData;
  logic [3:0]   oMstAck;
  logic [3:0]   oMstErr;
  logic [31:0]  oMstRData;
  logic         oSlvReq;
  logic [0:0]   oSlvCmd;
  logic [11:0]  oSlvAddr;
  logic [3:0]   oSlvSel;
  logic [31:0]  oSlvWData;
  logic         iSlvAck;
  logic [31:0]  iSlvRData;

  int errors = 0;
  int checks = 0;

  slave_arb dut (
    .iClk      (iClk),
    .iRst_n    (iRst_n),
    .iMstReq   (iMstReq),
    .iMstCmd   (iMstCmd),
    .iMstAddr  (iMstAddr),
    .iMstSel   (iMstSel),
    .iMstWData (iMstWData),
    .oMstAck   (oMstAck),
    .oMstErr   (oMstErr),
    .oMstRData (oMstRData),
    .oSlvReq   (oSlvReq),
    .oSlvCmd   (oSlvCmd),
    .oSlvAddr  (oSlvAddr),
    .oSlvSel   (oSlvSel),
    .oSlvWData (oSlvWData),
    .iSlvAck   (iSlvAck),
    .iSlvRData (iSlvRData)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] slv_data(input int n);
    return 32'hC0DE_0000 | 32'(iMstAddr[n*12 +: 12]);
  endfunction

  task automatic do_reset();
    iRst_n    = 1'b0;
    iMstReq   = '0;
    iSlvAck   = 1'b0;
    iSlvRData = '0;
    repeat (2) @(negedge iClk);
    iRst_n = 1'b1;
    @(negedge iClk);
  endtask

  // Plays the slave: acks on the ack_at-th BUSY cycle (0 = never) with data derived
  // from the address. Returns at the negedge where an ack is visible, or after budget.
  task automatic wait_ack(input int budget, input int ack_at, output logic [3:0] ack,
                          output int busy_cyc);
    ack      = '0;
    busy_cyc = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge iClk);
      if (oMstAck != 4'b0000) begin
        ack       = oMstAck;
        iSlvAck   = 1'b0;
        iSlvRData = '0;
        return;
      end
      if (oSlvReq) busy_cyc++;
      iSlvAck   = oSlvReq && (busy_cyc == ack_at);
      iSlvRData = iSlvAck ? (32'hC0DE_0000 | 32'(oSlvAddr)) : 32'h0;
    end
    iSlvAck = 1'b0;
  endtask

  logic [3:0] ack;
  int         bc;
  int         exp_order[5] = '{0, 1, 2, 3, 0};

  initial begin
    iMstCmd   = 4'b1010;
    iMstAddr  = {12'h430, 12'h320, 12'h210, 12'h004};
    iMstSel   = 16'h8421;
    iMstWData = {32'hDDDD_0003, 32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};
    iRst_n    = 1'b0;
    iMstReq   = '0;
    iSlvAck   = 1'b0;
    iSlvRData = '0;

    // Reset state
    @(negedge iClk);
    check("rst_slvreq", 32'(oSlvReq), 32'd0);
    check("rst_ack", 32'(oMstAck), 32'd0);
    check("rst_err", 32'(oMstErr), 32'd0);
    check("rst_rdata", oMstRData, 32'd0);
    check("rst_addr", 32'(oSlvAddr), 32'd0);
    @(negedge iClk);
    iRst_n = 1'b1;
    @(negedge iClk);

    // Single transaction, slave acks 3 cycles after oSlvReq
    iMstReq = 4'b0001;
    @(negedge iClk);
    check("t1_slvreq", 32'(oSlvReq), 32'd1);
    check("t1_addr", 32'(oSlvAddr), 32'h004);
    check("t1_cmd", 32'(oSlvCmd), 32'd0);
    check("t1_sel", 32'(oSlvSel), 32'h1);
    check("t1_wdata", oSlvWData, 32'hAAAA_0000);
    check("t1_noack", 32'(oMstAck), 32'd0);
    repeat (2) @(negedge iClk);
    check("t1_slvreq_hold", 32'(oSlvReq), 32'd1);
    check("t1_addr_hold", 32'(oSlvAddr), 32'h004);
    @(negedge iClk);
    iSlvAck   = 1'b1;
    iSlvRData = 32'hA5A5_A5A5;
    @(negedge iClk);
    iSlvAck   = 1'b0;
    iSlvRData = '0;
    check("t1_ack", 32'(oMstAck), 32'h1);
    check("t1_rdata", oMstRData, 32'hA5A5_A5A5);
    check("t1_err", 32'(oMstErr), 32'd0);
    check("t1_slvreq_low", 32'(oSlvReq), 32'd0);
    @(negedge iClk);
    check("t1_ack_pulse", 32'(oMstAck), 32'd0);
    check("t1_rdata_zero", oMstRData, 32'd0);
    check("t1_addr_kept", 32'(oSlvAddr), 32'h004);
    iSlvAck = 1'b1;  // stray ack while releasing
    @(negedge iClk);
    check("t1_stray_ack", 32'(oMstAck), 32'd0);
    check("t1_stray_req", 32'(oSlvReq), 32'd0);
    iSlvAck = 1'b0;
    iMstReq = '0;
    @(negedge iClk);

    // Round robin with all four masters requesting
    do_reset();
    iMstReq = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_ack(40, 1, ack, bc);
      check("rr_grant", 32'(ack), 32'(4'b0001 << exp_order[k]));
      check("rr_rdata", oMstRData, slv_data(exp_order[k]));
      check("rr_err", 32'(oMstErr), 32'd0);
      @(negedge iClk);
      iMstReq[exp_order[k]] = 1'b0;
      @(negedge iClk);
      iMstReq[exp_order[k]] = 1'b1;
    end
    iMstReq = '0;

    // Granted master keeps request high: others wait until it drops
    do_reset();
    iMstReq = 4'b0100;
    wait_ack(40, 1, ack, bc);
    check("hold_first", 32'(ack), 32'h4);
    iMstReq = 4'b0110;
    repeat (5) begin
      @(negedge iClk);
      check("hold_no_req", 32'(oSlvReq), 32'd0);
      check("hold_no_ack", 32'(oMstAck), 32'd0);
    end
    iMstReq = 4'b0010;
    wait_ack(40, 1, ack, bc);
    check("hold_second", 32'(ack), 32'h2);
    check("hold_rdata", oMstRData, slv_data(1));
    iMstReq = '0;

    // Reset mid-transaction
    do_reset();
    iMstReq = 4'b0001;
    for (int i = 0; i < 10; i++) begin
      @(negedge iClk);
      if (oSlvReq) break;
    end
    check("mrst_busy", 32'(oSlvReq), 32'd1);
    iMstReq = 4'b0011;
    #2 iRst_n = 1'b0;
    #1;
    check("mrst_slvreq", 32'(oSlvReq), 32'd0);
    check("mrst_addr", 32'(oSlvAddr), 32'd0);
    check("mrst_ack", 32'(oMstAck), 32'd0);
    @(negedge iClk);
    check("mrst_ack_hold", 32'(oMstAck), 32'd0);
    iRst_n = 1'b1;
    wait_ack(40, 1, ack, bc);
    check("mrst_next_grant", 32'(ack), 32'h1);
    iMstReq = '0;

`ifdef SLAVE_ARB_TIMEOUT_EN
    // Slave never responds
    do_reset();
    iMstReq = 4'b0100;
    wait_ack(60, 0, ack, bc);
    check("to_ack", 32'(ack), 32'h4);
    check("to_busy_cycles", 32'(bc), 32'd16);
    check("to_err", 32'(oMstErr), 32'h4);
    check("to_rdata", oMstRData, 32'hFFFF_FFFF);
    @(negedge iClk);
    check("to_err_pulse", 32'(oMstErr), 32'd0);
    iMstReq = '0;
    @(negedge iClk);

    // Ack on the expiry cycle wins
    iMstReq = 4'b0001;
    wait_ack(60, 16, ack, bc);
    check("to_late_ack", 32'(ack), 32'h1);
    check("to_late_cycles", 32'(bc), 32'd16);
    check("to_late_err", 32'(oMstErr), 32'd0);
    check("to_late_rdata", oMstRData, slv_data(0));
    iMstReq = '0;
`else
    check("no_to_err", 32'(oMstErr), 32'd0);
`endif

    @(negedge iClk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
